// File: rtl/wb_dec_pkg.sv
// Shared types and constants for the parametrised Wishbone decoder.
// State encoding, error read data and the default status address.
package wb_dec_pkg;

    localparam int DW = 32;

    localparam logic [DW-1:0] ERR_DATA     = 32'hDEAD_BEEF;
    localparam logic [DW-1:0] DEF_STAT_ADR = 32'h3000_0F00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_dec_match.sv
// Base/mask address compare against every slave window.
// Lowest-index hit wins; result is a hit flag plus a one-hot select.
module wb_dec_match
    import wb_dec_pkg::*;
#(
    parameter int                    N_SLV    = 5,
    parameter logic [DW*N_SLV-1:0]   SLV_BASE = {N_SLV{32'h0}},
    parameter logic [DW*N_SLV-1:0]   SLV_MASK = {N_SLV{32'h0}}
) (
    input  logic [DW-1:0]    i_adr,
    output logic             o_hit,
    output logic [N_SLV-1:0] o_onehot
);

    logic             w_found;
    logic [N_SLV-1:0] w_onehot;

    // Walk slaves from index 0 up so the first match blocks later ones.
    always_comb begin
        w_found  = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!w_found &&
                ((i_adr & SLV_MASK[DW*i +: DW]) == SLV_BASE[DW*i +: DW])) begin
                w_onehot[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    assign o_hit    = w_found;
    assign o_onehot = w_onehot;

endmodule

// File: rtl/wb_decode_n.sv
// Wishbone master-to-N-slave router: registered request/response, timeout.
// Optional status counters compiled in with macro WB_DEC_STATS_EN.
module wb_decode_n
    import wb_dec_pkg::*;
#(
    parameter int                    N_SLV    = 5,
    parameter logic [DW*N_SLV-1:0]   SLV_BASE = {N_SLV{32'h0}},
    parameter logic [DW*N_SLV-1:0]   SLV_MASK = {N_SLV{32'h0}},
    parameter int                    TIMEOUT  = 255
`ifdef WB_DEC_STATS_EN
    ,
    parameter logic [DW-1:0]         STAT_ADR = DEF_STAT_ADR
`endif
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [DW-1:0]       wbs_dat_i,
    input  logic [DW-1:0]       wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [DW-1:0]       wbs_dat_o,
    output logic [N_SLV-1:0]    s_valid_o,
    output logic                s_we_o,
    output logic [3:0]          s_sel_o,
    output logic [DW-1:0]       s_dat_o,
    output logic [DW-1:0]       s_adr_o,
    input  logic [N_SLV-1:0]    s_ack_i,
    input  logic [DW*N_SLV-1:0] s_dat_i,
    output logic                err_irq_o
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t             r_state;
    logic               r_ack;
    logic [DW-1:0]      r_rdat;
    logic [N_SLV-1:0]   r_valid;
    logic               r_we;
    logic [3:0]         r_sel;
    logic [DW-1:0]      r_dat;
    logic [DW-1:0]      r_adr;
    logic               r_irq;
    logic [15:0]        r_cnt;

    state_t             w_state_nxt;
    logic               w_ack_nxt;
    logic [DW-1:0]      w_rdat_nxt;
    logic [N_SLV-1:0]   w_valid_nxt;
    logic               w_we_nxt;
    logic [3:0]         w_sel_nxt;
    logic [DW-1:0]      w_dat_nxt;
    logic [DW-1:0]      w_adr_nxt;
    logic               w_irq_nxt;
    logic [15:0]        w_cnt_nxt;

    logic               w_req;
    logic               w_hit;
    logic [N_SLV-1:0]   w_onehot;
    logic               w_slv_ack;
    logic [DW-1:0]      w_slv_dat;
    logic               w_stat_hit;
    logic [DW-1:0]      w_stat_word;

    wb_dec_match #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_match (
        .i_adr    (wbs_adr_i),
        .o_hit    (w_hit),
        .o_onehot (w_onehot)
    );

    assign w_req     = wbs_cyc_i & wbs_stb_i;
    assign w_slv_ack = |(s_ack_i & r_valid);

    // Read data of the slave currently selected by the held one-hot.
    always_comb begin
        w_slv_dat = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_valid[i]) begin
                w_slv_dat = w_slv_dat | s_dat_i[DW*i +: DW];
            end
        end
    end

`ifdef WB_DEC_STATS_EN
    logic [15:0] r_to_cnt;
    logic [15:0] r_um_cnt;
    logic        w_um_evt;
    logic        w_to_evt;
    logic        w_clr_evt;

    assign w_stat_hit  = (wbs_adr_i == STAT_ADR);
    assign w_stat_word = {r_to_cnt, r_um_cnt};

    assign w_um_evt  = (r_state == ST_IDLE) & w_req &
                       ~w_stat_hit & ~w_hit;
    assign w_to_evt  = (r_state == ST_BUSY) & wbs_cyc_i &
                       ~w_slv_ack & (r_cnt == TO_LAST);
    assign w_clr_evt = (r_state == ST_IDLE) & w_req &
                       w_stat_hit & wbs_we_i;

    // Saturating error counters; a status write clears both.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_to_cnt <= '0;
            r_um_cnt <= '0;
        end else if (w_clr_evt) begin
            r_to_cnt <= '0;
            r_um_cnt <= '0;
        end else begin
            if (w_to_evt && r_to_cnt != 16'hFFFF) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
            if (w_um_evt && r_um_cnt != 16'hFFFF) begin
                r_um_cnt <= r_um_cnt + 16'd1;
            end
        end
    end
`else
    assign w_stat_hit  = 1'b0;
    assign w_stat_word = '0;
`endif

    // Next-state and next-register values for the transaction FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_rdat_nxt  = r_rdat;
        w_valid_nxt = r_valid;
        w_we_nxt    = r_we;
        w_sel_nxt   = r_sel;
        w_dat_nxt   = r_dat;
        w_adr_nxt   = r_adr;
        w_irq_nxt   = r_irq;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_req) begin
                    w_we_nxt  = wbs_we_i;
                    w_sel_nxt = wbs_sel_i;
                    w_dat_nxt = wbs_dat_i;
                    w_adr_nxt = wbs_adr_i;
                    if (w_stat_hit) begin
                        w_state_nxt = ST_RESP;
                        w_ack_nxt   = 1'b1;
                        w_rdat_nxt  = wbs_we_i ? '0 : w_stat_word;
                    end else if (w_hit) begin
                        w_state_nxt = ST_BUSY;
                        w_valid_nxt = w_onehot;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_ack_nxt   = 1'b1;
                        w_rdat_nxt  = ERR_DATA;
                        w_irq_nxt   = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (!wbs_cyc_i) begin
                    // Master abandoned the cycle: release silently.
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (w_slv_ack) begin
                    w_state_nxt = ST_RESP;
                    w_ack_nxt   = 1'b1;
                    w_rdat_nxt  = r_we ? '0 : w_slv_dat;
                    w_valid_nxt = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = ST_RESP;
                    w_ack_nxt   = 1'b1;
                    w_rdat_nxt  = ERR_DATA;
                    w_irq_nxt   = 1'b1;
                    w_valid_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_rdat  <= '0;
            r_valid <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_adr   <= '0;
            r_irq   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_rdat  <= w_rdat_nxt;
            r_valid <= w_valid_nxt;
            r_we    <= w_we_nxt;
            r_sel   <= w_sel_nxt;
            r_dat   <= w_dat_nxt;
            r_adr   <= w_adr_nxt;
            r_irq   <= w_irq_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdat;
    assign s_valid_o = r_valid;
    assign s_we_o    = r_we;
    assign s_sel_o   = r_sel;
    assign s_dat_o   = r_dat;
    assign s_adr_o   = r_adr;
    assign err_irq_o = r_irq;

endmodule

// File: tb/tb_wb_decode_n.sv
// Randomised self-checking bench for wb_decode_n (3 slaves, TIMEOUT 8).
// Expected results come from a transaction-level model of the decoder.
module tb_wb_decode_n;

    localparam int          N    = 3;
    localparam int          TO   = 8;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
    localparam logic [31:0] SADR = 32'h3000_0F00;

    logic            clk = 1'b0;
    logic            rst;
    logic            cyc, stb, we;
    logic [3:0]      sel;
    logic [31:0]     wdat, adr;
    logic            ack;
    logic [31:0]     rdat;
    logic [N-1:0]    s_valid;
    logic            s_we;
    logic [3:0]      s_sel;
    logic [31:0]     s_dato, s_adr;
    logic [N-1:0]    s_ack;
    logic [N*32-1:0] s_dat;
    logic            irq;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] base_a [N] = '{32'h3000_0000, 32'h3000_0100, 32'h3800_0000};
    logic [31:0] mask_a [N] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFF00_0000};

    bit exp_irq = 1'b0;
    int m_to    = 0;
    int m_um    = 0;

    always #5 clk = ~clk;

    wb_decode_n #(
        .N_SLV    (N),
        .SLV_BASE ({32'h3800_0000, 32'h3000_0100, 32'h3000_0000}),
        .SLV_MASK ({32'hFF00_0000, 32'hFFFF_FF00, 32'hFFFF_FF00}),
        .TIMEOUT  (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (wdat),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .s_valid_o (s_valid),
        .s_we_o    (s_we),
        .s_sel_o   (s_sel),
        .s_dat_o   (s_dato),
        .s_adr_o   (s_adr),
        .s_ack_i   (s_ack),
        .s_dat_i   (s_dat),
        .err_irq_o (irq)
    );

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & mask_a[i]) == base_a[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit is_stat(input logic [31:0] a);
`ifdef WB_DEC_STATS_EN
        return a == SADR;
`else
        return (a == SADR) && 1'b0;
`endif
    endfunction

    // One master transaction; slave idx acks after 'delay' valid cycles.
    task automatic do_txn(input logic [31:0] a, input logic w,
                          input logic [31:0] wd, input logic [3:0] sl,
                          input int delay, input logic [31:0] sd,
                          input bit noise, input string nm);
        int          idx, e_ack_k, e_vn, ack_k, n_ack, vc;
        logic [31:0] e_d, g_d, g_adr, g_sd;
        logic [3:0]  g_sel;
        logic        g_we;
        logic [N-1:0] first_v;
        bit          st;
        idx = decode(a);
        st  = is_stat(a);
        if (st) begin
            idx = -1;
            e_ack_k = 1; e_vn = 0;
            e_d = w ? 32'h0 : {16'(m_to), 16'(m_um)};
            if (w) begin m_to = 0; m_um = 0; end
        end else if (idx < 0) begin
            e_ack_k = 1; e_vn = 0; e_d = ERR;
            exp_irq = 1'b1;
            if (m_um < 65535) m_um++;
        end else if (delay >= 0 && delay <= TO - 1) begin
            e_ack_k = delay + 2; e_vn = delay + 1;
            e_d = w ? 32'h0 : sd;
        end else begin
            e_ack_k = TO + 1; e_vn = TO; e_d = ERR;
            exp_irq = 1'b1;
            if (m_to < 65535) m_to++;
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = wd; sel = sl;
        ack_k = -1; n_ack = 0; vc = 0; first_v = '0;
        g_d = '0; g_adr = '0; g_sd = '0; g_sel = '0; g_we = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            s_ack = '0;
            if (s_valid != '0) begin
                if (vc == 0) first_v = s_valid;
                vc++;
            end
            if (ack) begin
                n_ack++;
                if (ack_k < 0) begin
                    ack_k = k; g_d = rdat; g_adr = s_adr;
                    g_sd = s_dato; g_sel = s_sel; g_we = s_we;
                end
                cyc = 1'b0; stb = 1'b0;
            end
            if (s_valid != '0 && idx >= 0 && vc - 1 == delay) begin
                s_ack[idx] = 1'b1;
                s_dat[32*idx +: 32] = sd;
            end
            if (noise) begin
                for (int j = 0; j < N; j++) begin
                    if (j != idx && $urandom_range(0, 1) == 1) begin
                        s_ack[j] = 1'b1;
                        s_dat[32*j +: 32] = $urandom;
                    end
                end
            end
            if (k >= e_ack_k + 2) break;
        end
        cyc = 1'b0; stb = 1'b0; s_ack = '0;
        n_chk++;
        if (ack_k !== e_ack_k) begin
            n_fail++;
            $display("FAIL %s ack_cycle got %0d want %0d", nm, ack_k, e_ack_k);
        end
        n_chk++;
        if (n_ack !== 1) begin
            n_fail++;
            $display("FAIL %s ack_count got %0d want 1", nm, n_ack);
        end
        n_chk++;
        if (g_d !== e_d) begin
            n_fail++;
            $display("FAIL %s rdata got %h want %h", nm, g_d, e_d);
        end
        n_chk++;
        if (vc !== e_vn) begin
            n_fail++;
            $display("FAIL %s valid_cycles got %0d want %0d", nm, vc, e_vn);
        end
        if (idx >= 0) begin
            n_chk++;
            if (first_v !== N'(1 << idx)) begin
                n_fail++;
                $display("FAIL %s onehot got %b want %b",
                         nm, first_v, N'(1 << idx));
            end
        end
        n_chk++;
        if ({g_adr, g_sd, g_sel, g_we} !== {a, wd, sl, w}) begin
            n_fail++;
            $display("FAIL %s s_bus got %h/%h/%h/%b want %h/%h/%h/%b",
                     nm, g_adr, g_sd, g_sel, g_we, a, wd, sl, w);
        end
        n_chk++;
        if (irq !== exp_irq) begin
            n_fail++;
            $display("FAIL %s err_irq got %b want %b", nm, irq, exp_irq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = '0; wdat = '0; adr = '0; s_ack = '0; s_dat = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({ack, s_valid, irq} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b%b%b want 0",
                     ack, s_valid, irq);
        end
        n_chk++;
        if ({rdat, s_adr, s_dato, s_sel, s_we} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got %h/%h/%h/%h/%b want 0",
                     rdat, s_adr, s_dato, s_sel, s_we);
        end
        rst = 1'b0;
        exp_irq = 1'b0; m_to = 0; m_um = 0;
        @(negedge clk);
    endtask

    task automatic test_read();
        do_txn(32'h3000_0104, 1'b0, 32'h0, 4'hF, 2,
               32'h1234_5678, 1'b0, "read_s1");
    endtask

    task automatic test_write();
        do_txn(32'h3800_0010, 1'b1, 32'hA5A5_A5A5, 4'hF, 1,
               32'h5555_0000, 1'b0, "write_s2");
    endtask

    task automatic test_unmapped();
        do_txn(32'h3000_0200, 1'b0, 32'h0, 4'hF, 0,
               32'h0, 1'b0, "unmapped");
    endtask

    task automatic test_timeout();
        do_txn(32'h3000_0010, 1'b0, 32'h0, 4'hF, -1,
               32'h0, 1'b0, "timeout");
    endtask

    task automatic test_ack_at_timeout();
        do_txn(32'h3000_0120, 1'b0, 32'h0, 4'h3, TO - 1,
               32'hCAFE_F00D, 1'b0, "ack_on_last");
    endtask

    task automatic test_stats();
        do_txn(SADR, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, "stat_rd");
        do_txn(SADR, 1'b1, 32'h0, 4'hF, 0, 32'h0, 1'b0, "stat_wr");
        do_txn(SADR, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, "stat_rd2");
    endtask

    task automatic test_abort();
        int n_ack;
        n_ack = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        adr = 32'h3000_0010; sel = 4'hF; wdat = '0;
        @(negedge clk);
        n_chk++;
        if (s_valid !== 3'b001) begin
            n_fail++;
            $display("FAIL abort_valid got %b want 001", s_valid);
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        n_chk++;
        if (s_valid !== 3'b000 || n_ack != 0) begin
            n_fail++;
            $display("FAIL abort_drop got valid=%b acks=%0d want 000/0",
                     s_valid, n_ack);
        end
        do_txn(32'h3000_0144, 1'b0, 32'h0, 4'hF, 0,
               32'h0BAD_CAFE, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        int          kind;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            if (kind < N) a = base_a[kind] | ($urandom & ~mask_a[kind]);
            else a = 32'h3000_0200 | 32'($urandom_range(0, 255));
            do_txn(a, 1'($urandom_range(0, 1)), $urandom,
                   4'($urandom_range(0, 15)), $urandom_range(0, 10),
                   $urandom, 1'b1, "random");
        end
    endtask

    task automatic test_reset_mid();
        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        adr = 32'h3812_3456; sel = 4'hF;
        @(negedge clk);
        n_chk++;
        if (s_valid !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_valid got %b want 100", s_valid);
        end
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({s_valid, ack, irq} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_abort got %b/%b/%b want 0/0/0",
                     s_valid, ack, irq);
        end
        rst = 1'b0;
        exp_irq = 1'b0; m_to = 0; m_um = 0;
        @(negedge clk);
        do_txn(32'h3000_0001, 1'b0, 32'h0, 4'hF, 0,
               32'h600D_600D, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
`ifdef WB_DEC_STATS_EN
        test_stats();
`endif
        test_ack_at_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
